// File: rtl/cmd_serializer_pkg.sv
// Shared definitions for the SD command serializer and its CRC7 engine:
// FSM encoding, frame geometry, CRC polynomial and the command payload type.
package cmd_serializer_pkg;

  localparam int unsigned FRAME_LEN = 48;
  localparam int unsigned HDR_LEN   = 40;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned CRC_W     = 7;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned ARG_W     = 32;

  localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [ARG_W-1:0] argument;
  } cmd_req_t;

  // Frame bits 47..8: start bit, transmission bit, index, argument.
  function automatic logic [HDR_LEN-1:0] cmd_header(input cmd_req_t req);
    return {1'b0, 1'b1, req.index, req.argument};
  endfunction

endpackage

// File: rtl/cmd_serializer_if.sv
// Host request and pad-side signals of the command serializer.
interface cmd_serializer_if;
  import cmd_serializer_pkg::*;

  logic             iStart;
  logic [IDX_W-1:0] iCommand_index;
  logic [ARG_W-1:0] iArgument;
  logic             oEnable;
  logic             oOutput_input;
  logic             oData_in;
  logic             oBusy;
  logic             oDone;

  modport master (
    output iStart,
    output iCommand_index,
    output iArgument,
    input  oEnable,
    input  oOutput_input,
    input  oData_in,
    input  oBusy,
    input  oDone
  );

  modport slave (
    input  iStart,
    input  iCommand_index,
    input  iArgument,
    output oEnable,
    output oOutput_input,
    output oData_in,
    output oBusy,
    output oDone
  );

endinterface

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1); clear with enable seeds the first bit from zero,
// so a frame's first bit can be absorbed on the same edge that restarts the CRC.
module crc7_serial
  import cmd_serializer_pkg::*;
(
  input  logic             iSD_clock,
  input  logic             iReset_n,
  input  logic             iClear,
  input  logic             iEnable,
  input  logic             iBit,
  output logic [CRC_W-1:0] oCrc
);

  logic [CRC_W-1:0] r_crc;
  logic [CRC_W-1:0] w_seed;
  logic [CRC_W-1:0] w_step;
  logic             w_feedback;

  always_comb begin
    w_seed     = iClear ? '0 : r_crc;
    w_feedback = iBit ^ w_seed[CRC_W-1];
    w_step     = {w_seed[CRC_W-2:0], 1'b0} ^ (w_feedback ? CRC7_POLY : '0);
  end

  always_ff @(posedge iSD_clock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_crc <= '0;
    end else if (iEnable) begin
      r_crc <= w_step;
    end else if (iClear) begin
      r_crc <= '0;
    end
  end

  assign oCrc = r_crc;

endmodule

// File: rtl/cmd_serializer.sv
// SD CMD-line serializer: accepts a command, shifts the 48-bit frame out MSB first
// with a serially computed CRC7, then holds the line released for pGAP_CYCLES clocks.
module cmd_serializer
  import cmd_serializer_pkg::*;
#(
  parameter int unsigned pGAP_CYCLES = 8
) (
  input  logic             iSD_clock,
  input  logic             iReset_n,
  cmd_serializer_if.slave  bus
);

  localparam int unsigned GAP_W    = (pGAP_CYCLES > 1) ? $clog2(pGAP_CYCLES) : 1;
  localparam int unsigned GAP_LOAD = (pGAP_CYCLES > 0) ? pGAP_CYCLES - 1 : 0;
  localparam int unsigned CRC_CNT  = 8;
  localparam int unsigned SHR_W    = HDR_LEN - 1;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [SHR_W-1:0] r_frame;
  logic             r_enable;
  logic             r_dir;
  logic             r_data;
  logic             r_busy;
  logic             r_done;

  logic [1:0]         w_state_nxt;
  logic [CNT_W-1:0]   w_bit_cnt_nxt;
  logic [GAP_W-1:0]   w_gap_cnt_nxt;
  logic [SHR_W-1:0]   w_frame_nxt;
  logic               w_bit_nxt;
  logic               w_done_nxt;
  logic               w_crc_clr;
  logic               w_crc_en;
  logic [CRC_W-1:0]   w_crc;
  logic [HDR_LEN-1:0] w_hdr;
  cmd_req_t           w_req;

  assign w_req.index    = bus.iCommand_index;
  assign w_req.argument = bus.iArgument;
  assign w_hdr          = cmd_header(w_req);

  crc7_serial u_crc7 (
    .iSD_clock (iSD_clock),
    .iReset_n  (iReset_n),
    .iClear    (w_crc_clr),
    .iEnable   (w_crc_en),
    .iBit      (w_bit_nxt),
    .oCrc      (w_crc)
  );

  // Next-state logic; w_bit_nxt is the bit that will sit on the line next cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_frame_nxt   = r_frame;
    w_bit_nxt     = 1'b1;
    w_done_nxt    = 1'b0;
    w_crc_clr     = 1'b0;
    w_crc_en      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.iStart) begin
          w_state_nxt   = ST_SHIFT;
          w_bit_cnt_nxt = CNT_W'(FRAME_LEN - 1);
          w_frame_nxt   = w_hdr[SHR_W-1:0];
          w_bit_nxt     = w_hdr[HDR_LEN-1];
          w_crc_clr     = 1'b1;
          w_crc_en      = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (r_bit_cnt == CNT_W'(0)) begin
          w_done_nxt = 1'b1;
          if (pGAP_CYCLES == 0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt   = ST_GAP;
            w_gap_cnt_nxt = GAP_W'(GAP_LOAD);
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
          if (r_bit_cnt > CNT_W'(CRC_CNT)) begin
            // Header bits still feed the CRC as they are loaded onto the line.
            w_bit_nxt   = r_frame[SHR_W-1];
            w_frame_nxt = {r_frame[SHR_W-2:0], 1'b0};
            w_crc_en    = 1'b1;
          end else if (r_bit_cnt > CNT_W'(1)) begin
            w_bit_nxt = w_crc[3'(r_bit_cnt - CNT_W'(2))];
          end else begin
            w_bit_nxt = 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered pad outputs.
  always_ff @(posedge iSD_clock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_frame   <= '0;
      r_enable  <= 1'b0;
      r_dir     <= 1'b0;
      r_data    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_frame   <= w_frame_nxt;
      r_enable  <= 1'b1;
      r_dir     <= (w_state_nxt == ST_SHIFT);
      r_data    <= (w_state_nxt == ST_SHIFT) ? w_bit_nxt : 1'b1;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= w_done_nxt;
    end
  end

  assign bus.oEnable       = r_enable;
  assign bus.oOutput_input = r_dir;
  assign bus.oData_in      = r_data;
  assign bus.oBusy         = r_busy;
  assign bus.oDone         = r_done;

endmodule

// File: doc/cmd_serializer.md
CMD_SERIALIZER -- requirements
Module: cmd_serializer

Interface
REQ-001 SHALL have parameter pGAP_CYCLES, default 8, giving the minimum number of idle clocks after a command's end bit (SD Ncc).
REQ-002 SHALL have port iSD_clock, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port iReset_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port iStart, input, 1, a command request, sampled only when oBusy=0.
REQ-005 SHALL have port iCommand_index, input, 6, the command index, sampled with iStart.
REQ-006 SHALL have port iArgument, input, 32, the command argument, sampled with iStart.
REQ-007 SHALL have port oEnable, output, 1, the pad enable; connects to the downstream pad iEnable.
REQ-008 SHALL have port oOutput_input, output, 1, the pad direction (1=drive CMD line, 0=release); connects to pad iOutput_input.
REQ-009 SHALL have port oData_in, output, 1, the serial CMD bit; connects to pad iData_in.
REQ-010 SHALL have port oBusy, output, 1; high from acceptance until the gap completes.
REQ-011 SHALL have port oDone, output, 1, a one-cycle pulse after the end bit.

Function
REQ-012 SHALL build a 48-bit frame, MSB first: start bit 0, transmission bit 1, index[5:0], argument[31:0], CRC7[6:0], end bit 1.
REQ-013 SHALL compute CRC7 serially over frame bits 47..8 (40 bits), polynomial x^7+x^3+1, register cleared at acceptance.
REQ-014 SHALL implement FSM states IDLE, SHIFT and GAP.
REQ-015 SHALL take IDLE->SHIFT on iStart=1 at edge k; index and argument are latched at that edge.
REQ-016 SHALL drive frame bit 47 at cycle k+1 and bit 0 (end bit) at cycle k+48, one bit per clock.
REQ-017 SHALL take SHIFT->GAP after the end bit, using a 6-bit bit counter from 47 down to 0.
REQ-018 SHALL stay in GAP exactly pGAP_CYCLES cycles, then go GAP->IDLE; oBusy is low from cycle k+49+pGAP_CYCLES.
REQ-019 SHALL drive oEnable=1, oOutput_input=1 and oData_in=frame bit in SHIFT only.
REQ-020 SHALL drive oEnable=1, oOutput_input=0 and oData_in=1 in IDLE and GAP (line released, pulled high).
REQ-021 SHALL assert oDone only in the first GAP cycle (k+49).
REQ-022 SHALL keep oBusy=1 in SHIFT and GAP and 0 in IDLE.
REQ-023 SHALL ignore iStart while oBusy=1; no queuing and no effect on the frame in flight.
REQ-024 SHALL accept a new iStart in the first IDLE cycle after GAP; back-to-back start bits are spaced exactly 48+pGAP_CYCLES+1 cycles apart.
REQ-025 SHALL ignore iCommand_index and iArgument changes after acceptance.
REQ-026 SHALL handle pGAP_CYCLES=0 by going SHIFT->IDLE with no GAP state, with oDone asserted in that IDLE cycle.

Reset
REQ-027 SHALL, on iReset_n=0 at any time including mid-frame, immediately force state IDLE, oEnable=0, oOutput_input=0, oData_in=1, oBusy=0, oDone=0, counters=0 and CRC=0.
REQ-028 SHALL not abort a new frame on reset deassertion; the first start is accepted no earlier than the first rising edge with iReset_n=1.

Structure
REQ-029 SHALL place in a shared package the state encoding (IDLE/SHIFT/GAP), the frame length constant 48 and the CRC7 polynomial constant 7'h09.
REQ-030 SHALL implement CRC7 as one sub-module, crc7_serial, with inputs clear, enable and bit and a 7-bit output, reusable by the future response receiver.
REQ-031 SHALL keep the rest of the logic (shift register, counters, FSM) in cmd_serializer; it connects directly to the pad with no glue logic.

Verification
REQ-032 SHALL test CMD0: index 0, arg 0x00000000 -> serial stream 0x400000000095 (CRC 0x4A), oDone at k+49.
REQ-033 SHALL test CMD8: index 8, arg 0x000001AA -> stream 0x48000001AA87 (CRC 0x43); oOutput_input=1 for exactly 48 cycles.
REQ-034 SHALL test CMD17: index 17, arg 0x00000000 -> stream 0x510000000055; iStart pulsed again at k+10 and k+30 -> ignored, frame unchanged.
REQ-035 SHALL test back-to-back: iStart held high, pGAP_CYCLES=8 -> second start bit at k+58, line high with oOutput_input=0 during cycles k+49..k+56.
REQ-036 SHALL test reset mid-frame: iReset_n low at k+20 -> same-cycle oBusy=0, oOutput_input=0, oData_in=1; after release a fresh CMD0 is correct bit-for-bit.
REQ-037 SHALL test boundary: pGAP_CYCLES=0 build with iStart held -> next start bit at k+50, oDone one cycle at k+49.
